// File: rtl/mmio_pkg.sv
// Shared constants for the memory-mapped responder: register byte offsets,
// STATUS bit positions and the default TX FIFO depth.
package mmio_pkg;

  localparam logic [7:0] MMIO_SCRATCH  = 8'h00;
  localparam logic [7:0] MMIO_MTIME_LO = 8'h04;
  localparam logic [7:0] MMIO_MTIME_HI = 8'h08;
  localparam logic [7:0] MMIO_TX_DATA  = 8'h0C;
  localparam logic [7:0] MMIO_STATUS   = 8'h10;

  localparam int STATUS_EMPTY_BIT    = 0;
  localparam int STATUS_FULL_BIT     = 1;
  localparam int STATUS_OVERFLOW_BIT = 2;
  localparam int STATUS_COUNT_LSB    = 3;
  localparam int STATUS_COUNT_MSB    = 6;

  localparam int MMIO_FIFO_DEPTH = 8;

endpackage

// File: rtl/mmio_responder_byte_fifo.sv
// Byte-wide TX FIFO. A push is refused when the FIFO is full before this
// cycle's pop; a pop is refused when empty. The head is read straight from
// storage, so a pushed byte only shows up on the cycle after the push.
module byte_fifo #(
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [7:0]       push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count,
  output logic [7:0]       head
);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is cleared on reset so the head never presents stale data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/mmio_responder.sv
// Memory-mapped responder beside the data SRAM: scratch register, 64-bit
// cycle counter with a latched upper-word shadow, and a byte TX FIFO that
// drains through a valid/ready port. Reads return data one cycle later.
module mmio_responder
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0001_0000,
  parameter int          FIFO_DEPTH = MMIO_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_read_i,
  input  logic [3:0]  data_write_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_in_i,
  output logic [31:0] data_out_o,
  output logic        tx_valid_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_ready_i
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic             selected;
  logic [7:0]       offset;
  logic [31:0]      scratch;
  logic [63:0]      counter;
  logic [31:0]      hi_shadow;
  logic             overflow;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [PTR_W:0]   fifo_count;
  logic             clear_overflow;
  logic [31:0]      status_word;
  logic [31:0]      read_data;

  // The two low address bits are masked off so any byte address hits its word.
  assign selected       = (data_addr_i[31:8] == BASE_ADDR[31:8]);
  assign offset         = data_addr_i[7:0] & 8'hFC;
  assign fifo_push      = selected && (offset == MMIO_TX_DATA) && data_write_i[0];
  assign fifo_pop       = tx_valid_o & tx_ready_i;
  assign clear_overflow = selected && (offset == MMIO_STATUS) && data_write_i[0]
                          && data_in_i[STATUS_OVERFLOW_BIT];
  assign tx_valid_o     = ~fifo_empty;

  byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (data_in_i[7:0]),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (tx_data_o)
  );

  // STATUS view of the FIFO as it stands before this edge's push or pop.
  always_comb begin
    status_word                                      = '0;
    status_word[STATUS_EMPTY_BIT]                    = fifo_empty;
    status_word[STATUS_FULL_BIT]                     = fifo_full;
    status_word[STATUS_OVERFLOW_BIT]                 = overflow;
    status_word[STATUS_COUNT_MSB:STATUS_COUNT_LSB]   = 4'(fifo_count);
  end

  // Read mux over pre-write register values; holes and foreign addresses read 0.
  always_comb begin
    read_data = '0;
    if (selected) begin
      case (offset)
        MMIO_SCRATCH:  read_data = scratch;
        MMIO_MTIME_LO: read_data = counter[31:0];
        MMIO_MTIME_HI: read_data = hi_shadow;
        MMIO_STATUS:   read_data = status_word;
        default:       read_data = '0;
      endcase
    end
  end

  // Scratch register with per-byte write enables.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scratch <= '0;
    end else if (selected && (offset == MMIO_SCRATCH)) begin
      for (int b = 0; b < 4; b++) begin
        if (data_write_i[b]) scratch[8*b +: 8] <= data_in_i[8*b +: 8];
      end
    end
  end

  // Free-running cycle counter; wraps from all-ones back to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) counter <= '0;
    else      counter <= counter + 64'd1;
  end

  // Reading the low word freezes the matching upper word for a later HI read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_shadow <= '0;
    end else if (data_read_i && selected && (offset == MMIO_MTIME_LO)) begin
      hi_shadow <= counter[63:32];
    end
  end

  // Sticky overflow: set by a push into a full FIFO, cleared by a STATUS write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) overflow <= 1'b0;
    else      overflow <= (overflow & ~clear_overflow) | (fifo_push & fifo_full);
  end

  // Registered read data, held until the next read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             data_out_o <= '0;
    else if (data_read_i) data_out_o <= read_data;
  end

endmodule

// File: tb/tb_mmio_responder.sv
// Scoreboard bench for mmio_responder: a behavioural model predicts read data
// and the TX byte stream; a negedge monitor compares what the DUT presents.
module tb_mmio_responder;

  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam int          DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_read_i;
  logic [3:0]  data_write_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_in_i;
  logic [31:0] data_out_o;
  logic        tx_valid_o;
  logic [7:0]  tx_data_o;
  logic        tx_ready_i;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] exp_rd [$];
  logic [7:0]  exp_tx [$];
  logic [7:0]  model_q [$];
  logic [31:0] m_scratch;
  logic [63:0] m_mtime;
  logic [31:0] m_shadow;
  logic        m_ovf;
  logic        rd_seen = 1'b0;

  mmio_responder #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_read_i  (data_read_i),
    .data_write_i (data_write_i),
    .data_addr_i  (data_addr_i),
    .data_in_i    (data_in_i),
    .data_out_o   (data_out_o),
    .tx_valid_o   (tx_valid_o),
    .tx_data_o    (tx_data_o),
    .tx_ready_i   (tx_ready_i)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    m_scratch = '0;
    m_mtime   = '0;
    m_shadow  = '0;
    m_ovf     = 1'b0;
  endtask

  // Drive one cycle of inputs, predict its effects from the register-map rules,
  // then step past the edge. Entered and left at posedge+2.
  task automatic apply_stimulus(input logic rd, input logic [3:0] we,
                                input logic [31:0] addr, input logic [31:0] din,
                                input logic ready);
    logic        sel;
    logic [7:0]  off;
    logic [31:0] rv;
    logic        push_req;
    int          n;
    check_output("tx_valid", {31'b0, tx_valid_o}, {31'b0, model_q.size() != 0});
    data_read_i  = rd;
    data_write_i = we;
    data_addr_i  = addr;
    data_in_i    = din;
    tx_ready_i   = ready;
    sel = (addr[31:8] == BASE[31:8]);
    off = addr[7:0] & 8'hFC;
    n   = model_q.size();
    rv  = '0;
    if (sel) begin
      case (off)
        8'h00: rv = m_scratch;
        8'h04: rv = m_mtime[31:0];
        8'h08: rv = m_shadow;
        8'h10: rv = (32'(n) << 3) | (32'(m_ovf) << 2) | (32'(n == DEPTH) << 1) | 32'(n == 0);
        default: rv = '0;
      endcase
    end
    if (rd) begin
      exp_rd.push_back(rv);
      if (sel && off == 8'h04) m_shadow = m_mtime[63:32];
    end
    if (sel && off == 8'h00) begin
      for (int b = 0; b < 4; b++) if (we[b]) m_scratch[8*b +: 8] = din[8*b +: 8];
    end
    if (sel && off == 8'h10 && we[0] && din[2]) m_ovf = 1'b0;
    push_req = sel && off == 8'h0C && we[0];
    if (push_req && n == DEPTH) m_ovf = 1'b1;
    if (ready && n > 0) exp_tx.push_back(model_q.pop_front());
    if (push_req && n < DEPTH) model_q.push_back(din[7:0]);
    m_mtime = m_mtime + 64'd1;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int cycles, input logic ready);
    for (int i = 0; i < cycles; i++) apply_stimulus(1'b0, 4'b0, '0, '0, ready);
  endtask

  // Monitor: compare read data one cycle after each read and every TX handshake.
  always @(negedge clk) begin
    if (rd_seen) begin
      if (exp_rd.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL read_unexpected: got %h, expected no read data", data_out_o);
      end else begin
        check_output("read_data", data_out_o, exp_rd.pop_front());
      end
    end
    rd_seen = data_read_i && rst;
    if (rst && tx_valid_o && tx_ready_i) begin
      if (exp_tx.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL tx_unexpected: got %h, expected no transfer", tx_data_o);
      end else begin
        check_output("tx_data", {24'b0, tx_data_o}, {24'b0, exp_tx.pop_front()});
      end
    end
  end

  initial begin
    logic [7:0]  offs [8];
    logic [31:0] a;
    offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h0C, 8'h10, 8'h20, 8'hFC};
    rst = 1'b0;
    data_read_i = 1'b0; data_write_i = '0; data_addr_i = '0; data_in_i = '0;
    tx_ready_i = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check_output("reset_data_out", data_out_o, 32'h0);
    check_output("reset_tx_valid", {31'b0, tx_valid_o}, 32'h0);
    rst = 1'b1;

    // Status straight after reset, then scratch byte enables.
    apply_stimulus(1'b1, 4'b0, BASE | 32'h10, '0, 1'b0);
    apply_stimulus(1'b0, 4'b1111, BASE, 32'hDEAD_BEEF, 1'b0);
    apply_stimulus(1'b0, 4'b0010, BASE, 32'h0000_1200, 1'b0);
    apply_stimulus(1'b1, 4'b0, BASE, '0, 1'b0);
    idle(1, 1'b0);
    check_output("scratch_model", m_scratch, 32'hDEAD_12EF);

    // Counter snapshot across a low-word wrap.
    force dut.counter = 64'h0000_0001_FFFF_FFFC;
    #1;
    release dut.counter;
    m_mtime = 64'h0000_0001_FFFF_FFFC;
    apply_stimulus(1'b1, 4'b0, BASE | 32'h04, '0, 1'b0);
    idle(6, 1'b0);
    apply_stimulus(1'b1, 4'b0, BASE | 32'h08, '0, 1'b0);
    apply_stimulus(1'b1, 4'b0, BASE | 32'h04, '0, 1'b0);
    idle(4, 1'b0);
    apply_stimulus(1'b1, 4'b0, BASE | 32'h04, '0, 1'b0);
    idle(1, 1'b0);

    // Fill past full, check STATUS, clear overflow.
    for (int i = 1; i <= 9; i++) apply_stimulus(1'b0, 4'b0001, BASE | 32'h0C, 32'(i), 1'b0);
    apply_stimulus(1'b1, 4'b0, BASE | 32'h10, '0, 1'b0);
    apply_stimulus(1'b0, 4'b0001, BASE | 32'h10, 32'h4, 1'b0);
    apply_stimulus(1'b1, 4'b0, BASE | 32'h10, '0, 1'b0);
    idle(1, 1'b0);

    // Drain, then a second fill to exercise pointer wrap.
    idle(10, 1'b1);
    for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 4'b0001, BASE | 32'h0C, 32'hA0 + 32'(i), 1'b0);
    idle(7, 1'b1);

    // Simultaneous push and pop at count 3.
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 4'b0001, BASE | 32'h0C, 32'h30 + 32'(i), 1'b0);
    apply_stimulus(1'b0, 4'b0001, BASE | 32'h0C, 32'h33, 1'b1);
    apply_stimulus(1'b1, 4'b0, BASE | 32'h10, '0, 1'b0);
    idle(6, 1'b1);

    // Unmapped offset and foreign address.
    apply_stimulus(1'b1, 4'b0, BASE | 32'h20, '0, 1'b0);
    apply_stimulus(1'b0, 4'b1111, BASE | 32'h20, 32'hFFFF_FFFF, 1'b0);
    apply_stimulus(1'b0, 4'b1111, BASE ^ 32'h0000_0100, 32'h1234_5678, 1'b0);
    apply_stimulus(1'b1, 4'b0, BASE, '0, 1'b0);
    apply_stimulus(1'b1, 4'b0, BASE | 32'h10, '0, 1'b0);
    apply_stimulus(1'b1, 4'b0, BASE ^ 32'h0000_0100, '0, 1'b0);

    // Asynchronous reset with bytes waiting in the FIFO.
    for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 4'b0001, BASE | 32'h0C, 32'h50 + 32'(i), 1'b0);
    idle(1, 1'b0);
    #1;
    rst = 1'b0;
    #1;
    check_output("midreset_tx_valid", {31'b0, tx_valid_o}, 32'h0);
    check_output("midreset_data_out", data_out_o, 32'h0);
    model_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    apply_stimulus(1'b1, 4'b0, BASE | 32'h10, '0, 1'b1);
    apply_stimulus(1'b1, 4'b0, BASE | 32'h04, '0, 1'b1);

    // Randomised traffic over the whole map.
    for (int i = 0; i < 400; i++) begin
      a = BASE | 32'(offs[$urandom_range(0, 7)]) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) a = a ^ 32'h0000_0100;
      apply_stimulus(1'($urandom_range(0, 1)),
                     ($urandom_range(0, 2) == 0) ? 4'b0 : 4'($urandom),
                     a, $urandom, 1'($urandom_range(0, 1)));
    end

    idle(12, 1'b1);
    check_output("exp_rd_left", 32'(exp_rd.size()), 32'h0);
    check_output("exp_tx_left", 32'(exp_tx.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mmio_responder.md
# mmio_responder

Memory-mapped responder on the CPU data-memory port, answering the same access protocol the data SRAM answers: the same enable, byte-write-enable, address and write-data inputs, with read data one cycle later. It holds a scratch register, a 64-bit free-running cycle counter and an 8-entry byte TX FIFO. The FIFO drains through a valid/ready output port. It sits beside the data SRAM, selected by address decode in top.

## Interface
- `BASE_ADDR`, default 32'h0001_0000: base address of the block; bits [7:0] must be zero.
- `FIFO_DEPTH`, default 8: TX FIFO entries; must be a power of two.
- `clk` in, 1 bit: the only clock.
- `rst` in, 1 bit: reset, asynchronous, active-low. Asserting it clears all state immediately.
- `data_read_i` in, 1 bit: read enable, the same meaning as the SRAM OE.
- `data_write_i` in, 4 bits: byte write enables, active-high; bit n writes byte n.
- `data_addr_i` in, 32 bits: byte address.
- `data_in_i` in, 32 bits: write data.
- `data_out_o` out, 32 bits: read data, registered.
- `tx_valid_o` out, 1 bit: the FIFO head is valid.
- `tx_data_o` out, 8 bits: the FIFO head byte.
- `tx_ready_i` in, 1 bit: the consumer accepts the head byte.

## Operation
- The block is selected when `data_addr_i[31:8] == BASE_ADDR[31:8]`.
- The register offset is `data_addr_i[7:2]`. `data_addr_i[1:0]` is ignored.
- Register map:
  - 0x00 SCRATCH, read/write. Each byte is written only when its `data_write_i` bit is set.
  - 0x04 MTIME_LO, read-only. Returns counter[31:0]. The same read copies counter[63:32] into the HI shadow.
  - 0x08 MTIME_HI, read-only. Returns the HI shadow, not the live counter.
  - 0x0C TX_DATA, write-only. When `data_write_i[0]` is set, `data_in_i[7:0]` is pushed into the FIFO. Reads of TX_DATA return 0.
  - 0x10 STATUS:
    - [0] empty, [1] full, [2] overflow (sticky), [6:3] count, all other bits 0.
    - A write with `data_write_i[0]` set and `data_in_i[2]` = 1 clears overflow. No other STATUS bit is writable.
  - Any other offset, or an unselected address: writes are ignored and reads return 32'h0.
- Cycle counter: 64 bits, increments by 1 every cycle, and wraps from all-ones to 0. It is not writable.
- FIFO push:
  - Accepted only when the FIFO is not full before this cycle's pop.
  - If the FIFO is full, the byte is dropped and overflow is set. A push pushed one byte.
- FIFO pop:
  - A pop happens on any cycle where `tx_valid_o` and `tx_ready_i` are both high.
- Simultaneous push and pop on a non-empty, non-full FIFO: the count is unchanged and both pointers advance.
- `tx_valid_o` = count != 0. `tx_data_o` = the byte at the read pointer.
- Pointers are log2(FIFO_DEPTH) bits wide and wrap modulo the depth. The count is one bit wider than the pointers.
- Reset values:
  - `data_out_o` = 0, SCRATCH = 0, counter = 0, HI shadow = 0.
  - FIFO empty, pointers = 0, overflow = 0, `tx_valid_o` = 0.

## Timing
- Read latency is 1 cycle.
  - Address and `data_read_i` are sampled at rising edge N. `data_out_o` is valid after edge N.
  - `data_out_o` holds its value until the next edge where `data_read_i` is high.
- A write takes effect at the sampling edge. A read of the same register in the same cycle returns the pre-write value.
- STATUS reads reflect state before that edge's push or pop.
- FIFO:
  - A pushed byte makes `tx_valid_o` high in the following cycle. There is no fall-through.
  - The head changes in the cycle after a pop.
- Reset may arrive mid-transfer. It empties the FIFO and drops any pending head, and `tx_valid_o` falls asynchronously.

## Structure
- Package `mmio_pkg` holds:
  - Register offset constants: `MMIO_SCRATCH`, `MMIO_MTIME_LO`, `MMIO_MTIME_HI`, `MMIO_TX_DATA`, `MMIO_STATUS`.
  - STATUS bit index constants.
  - The default FIFO depth.
- Sub-module `byte_fifo` contains the storage, pointers and count. Its ports are push/pop strobes, full/empty/count, and head data.
- `mmio_responder` contains the address decode, the registers, the counter, the read mux and the `data_out_o` register.

## Test plan
- Reset then read STATUS: `data_out_o` = 32'h0000_0001, `tx_valid_o` = 0.
- SCRATCH byte enables:
  - Write 32'hDEAD_BEEF with `data_write_i` = 4'b1111, then write 32'h0000_1200 with 4'b0010.
  - Read SCRATCH: 32'hDEAD_12EF, one cycle after the read.
- Counter snapshot:
  - Read MTIME_LO, then read MTIME_HI after forcing the low word to wrap between the two reads.
  - MTIME_HI returns the pre-wrap upper word.
  - Two MTIME_LO reads K cycles apart differ by K.
- FIFO fill and overflow:
  - Hold `tx_ready_i` = 0 and push bytes 0x01..0x09.
  - STATUS = 32'h0000_0046 (count 8, full, overflow).
  - Byte 0x09 is lost.
  - Writing STATUS with bit 2 set clears overflow.
- FIFO drain:
  - Raise `tx_ready_i`. Bytes 0x01..0x08 appear on `tx_data_o` in order, one per cycle.
  - `tx_valid_o` falls after the eighth byte, and the pointers wrap correctly on a second fill.
- Simultaneous push and pop at count 3, plus an unmapped address:
  - Push and pop in the same cycle: count stays 3 and the order is preserved.
  - Read offset 0x20: returns 0. Write offset 0x20: changes no state.
